running_mean_gen: RTL and testbench

Produces the `running_mean` / `running_mean_valid` pair that the KNN comparator stage consumes. It averages the distances of the last `2**LOG_W` accepted neighbour entries over a sliding window, held in a circular buffer. It sits downstream of the comparator/top-K path and feeds its registered mean back to the comparator, which uses it as the acceptance threshold. A synchronous `clear` restarts the window at each new query point.

---
 rtl/running_mean_gen_pkg.sv | 20 ++
 rtl/rmean_window_buf.sv | 48 ++++
 rtl/running_mean_gen.sv | 110 +++++++++++
 tb/tb_running_mean_gen.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/running_mean_gen_pkg.sv
// Shared types for the KNN running-mean threshold path.
package running_mean_gen_pkg;

    localparam int unsigned KNN_DIST_W          = 32;
    localparam int unsigned KNN_IDX_W           = 16;
    localparam int unsigned RMEAN_LOG_W_DEFAULT = 3;

    typedef struct packed {
        logic                  valid;
        logic [KNN_IDX_W-1:0]  index;
        logic [KNN_DIST_W-1:0] distance;
    } knn_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } rmean_state_t;

endpackage

// File: rtl/rmean_window_buf.sv
// W-deep circular distance buffer; exposes the entry about to be overwritten.
module rmean_window_buf #(
    parameter int unsigned B     = 32,
    parameter int unsigned LOG_W = 3
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         wr_en,
    input  logic [B-1:0] wr_data,
    output logic [B-1:0] evict_data_c
);

    localparam int unsigned W = 1 << LOG_W;

    logic [B-1:0]     mem_q [W];
    logic [B-1:0]     mem_d [W];
    logic [LOG_W-1:0] wr_ptr_q;
    logic [LOG_W-1:0] wr_ptr_d;

    // Old slot is read combinationally so the accumulator can subtract it on the same edge.
    assign evict_data_c = mem_q[wr_ptr_q];

    // Contents survive clear; they are all rewritten before any eviction is used.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
        end else if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + LOG_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < int'(W); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/running_mean_gen.sv
// Sliding-window mean of accepted neighbour distances, fed back as the comparator threshold.
// Define RMEAN_MARGIN_EN to add a saturating (mean >> MARGIN_SHIFT) margin to the output.
module running_mean_gen
    import running_mean_gen_pkg::*;
#(
    parameter int unsigned B            = KNN_DIST_W,
    parameter int unsigned LOG_W        = RMEAN_LOG_W_DEFAULT,
    parameter int unsigned MARGIN_SHIFT = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clear,
    input  knn_entry_t   sample_in,
    input  logic         sample_valid,
    output logic         sample_ready,
    output logic [B-1:0] running_mean,
    output logic         running_mean_valid
);

    localparam int unsigned W  = 1 << LOG_W;
    localparam int unsigned SW = B + LOG_W;
    localparam int unsigned CW = LOG_W + 1;
    localparam int unsigned MW = B + 1;
`ifdef RMEAN_MARGIN_EN
    localparam bit MARGIN_EN = 1'b1;
`else
    localparam bit MARGIN_EN = 1'b0;
`endif

    rmean_state_t  state_q, state_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [CW-1:0] count_q, count_d;
    logic [B-1:0]  mean_q, mean_d;
    logic          valid_q, valid_d;

    logic          accept_c;
    logic [B-1:0]  din_c;
    logic [B-1:0]  evict_c;
    logic [B-1:0]  mean_plain_c;
    logic [MW-1:0] margin_c;
    logic          unused_idx;

    assign sample_ready = !clear;
    assign accept_c     = sample_valid && sample_in.valid && sample_ready;
    assign din_c        = B'(sample_in.distance);
    assign unused_idx   = ^sample_in.index;

    rmean_window_buf #(
        .B     (B),
        .LOG_W (LOG_W)
    ) u_buf (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear        (clear),
        .wr_en        (accept_c),
        .wr_data      (din_c),
        .evict_data_c (evict_c)
    );

    // Window state, accumulator and next output value.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        count_d = count_q;
        if (clear) begin
            state_d = EMPTY;
            sum_d   = '0;
            count_d = '0;
        end else if (accept_c) begin
            if (state_q == FULL) begin
                sum_d = sum_q + SW'(din_c) - SW'(evict_c);
            end else begin
                sum_d   = sum_q + SW'(din_c);
                count_d = count_q + CW'(1);
                state_d = (count_d == CW'(W)) ? FULL : FILL;
            end
        end

        mean_plain_c = B'(sum_d >> LOG_W);
        margin_c     = {1'b0, mean_plain_c} + MW'(mean_plain_c >> MARGIN_SHIFT);
        if (!MARGIN_EN) begin
            mean_d = mean_plain_c;
        end else if (margin_c[B]) begin
            mean_d = '1;
        end else begin
            mean_d = margin_c[B-1:0];
        end
        valid_d = (state_d == FULL);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            sum_q   <= '0;
            count_q <= '0;
            mean_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            mean_q  <= mean_d;
            valid_q <= valid_d;
        end
    end

    assign running_mean       = mean_q;
    assign running_mean_valid = valid_q;

endmodule

// File: tb/tb_running_mean_gen.sv
// Scoreboard bench for running_mean_gen with a 4-deep window.
module tb_running_mean_gen;
    import running_mean_gen_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        clear;
    knn_entry_t  sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic [31:0] running_mean;
    logic        running_mean_valid;

    typedef struct {
        logic [31:0] mean;
        logic        valid;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    running_mean_gen #(
        .B            (32),
        .LOG_W        (2),
        .MARGIN_SHIFT (2)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .clear              (clear),
        .sample_in          (sample_in),
        .sample_valid       (sample_valid),
        .sample_ready       (sample_ready),
        .running_mean       (running_mean),
        .running_mean_valid (running_mean_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] exp_out(input logic [31:0] m);
`ifdef RMEAN_MARGIN_EN
        logic [32:0] w;
        w = {1'b0, m} + 33'(m >> 2);
        return w[32] ? 32'hFFFF_FFFF : w[31:0];
`else
        return m;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    endtask

    // One driven cycle; the expected outputs after the next edge go to the scoreboard.
    task automatic step(input string nm, input logic sv, input logic ev, input logic [31:0] d,
                        input logic clr, input logic [31:0] em, input logic evld);
        @(negedge clock);
        sample_valid       = sv;
        sample_in.valid    = ev;
        sample_in.index    = 16'(d);
        sample_in.distance = d;
        clear              = clr;
        #1;
        chk({nm, " ready"}, 32'(sample_ready), 32'(!clr));
        exp_q.push_back('{exp_out(em), evld, nm});
    endtask

    task automatic acc(input string nm, input logic [31:0] d, input logic [31:0] em, input logic evld);
        step(nm, 1'b1, 1'b1, d, 1'b0, em, evld);
    endtask

    // Monitor: outputs after each edge are compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.name, " mean"},  running_mean,              e.mean);
                chk({e.name, " valid"}, 32'(running_mean_valid),   32'(e.valid));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n            = 1'b0;
        clear              = 1'b0;
        sample_valid       = 1'b0;
        sample_in          = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset mean",  running_mean,              32'd0);
        chk("reset valid", 32'(running_mean_valid),   32'd0);
        chk("reset ready", 32'(sample_ready),         32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        step("idle", 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);

        // Fill then slide: sums 10,30,60,100 -> 2,7,15,25; then 140 -> 35, 180 -> 45.
        acc("a10", 32'd10, 32'd2,  1'b0);
        acc("a20", 32'd20, 32'd7,  1'b0);
        acc("a30", 32'd30, 32'd15, 1'b0);
        acc("a40", 32'd40, 32'd25, 1'b1);
        acc("a50", 32'd50, 32'd35, 1'b1);
        acc("a60", 32'd60, 32'd45, 1'b1);
        step("hold", 1'b0, 1'b1, 32'd7, 1'b0, 32'd45, 1'b1);

        // Clear beats a simultaneous sample.
        step("clr+s100", 1'b1, 1'b1, 32'd100, 1'b1, 32'd0, 1'b0);
        acc("b4a", 32'd4, 32'd1, 1'b0);
        acc("b4b", 32'd4, 32'd2, 1'b0);
        acc("b4c", 32'd4, 32'd3, 1'b0);
        acc("b4d", 32'd4, 32'd4, 1'b1);

        // Entries with valid=0 (or sample_valid=0) are ignored.
        step("clr2",   1'b0, 1'b0, 32'd0,   1'b1, 32'd0, 1'b0);
        step("inv999", 1'b1, 1'b0, 32'd999, 1'b0, 32'd0, 1'b0);
        acc("c8a", 32'd8, 32'd2, 1'b0);
        step("inv999b", 1'b1, 1'b0, 32'd999, 1'b0, 32'd2, 1'b0);
        acc("c8b", 32'd8, 32'd4, 1'b0);
        step("nosv999", 1'b0, 1'b1, 32'd999, 1'b0, 32'd4, 1'b0);
        acc("c8c", 32'd8, 32'd6, 1'b0);
        step("inv999c", 1'b1, 1'b0, 32'd999, 1'b0, 32'd6, 1'b0);
        acc("c8d", 32'd8, 32'd8, 1'b1);
        step("inv999d", 1'b1, 1'b0, 32'd999, 1'b0, 32'd8, 1'b1);

        // Full-scale distances: the accumulator must not wrap.
        step("clr3", 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0);
        acc("maxa", 32'hFFFF_FFFF, 32'h3FFF_FFFF, 1'b0);
        acc("maxb", 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        acc("maxc", 32'hFFFF_FFFF, 32'hBFFF_FFFF, 1'b0);
        acc("maxd", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        acc("maxe", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

        // 100 x4: plain mean 100, or 125 with a quarter margin.
        step("clr4", 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0);
        acc("h100a", 32'd100, 32'd25,  1'b0);
        acc("h100b", 32'd100, 32'd50,  1'b0);
        acc("h100c", 32'd100, 32'd75,  1'b0);
        acc("h100d", 32'd100, 32'd100, 1'b1);

        // Asynchronous reset mid-fill.
        step("clr5", 1'b0, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0);
        acc("r40a", 32'd40, 32'd10, 1'b0);
        acc("r40b", 32'd40, 32'd20, 1'b0);
        @(posedge clock);
        #3;
        sample_valid = 1'b0;
        reset_n      = 1'b0;
        #1;
        chk("arst mean",  running_mean,            32'd0);
        chk("arst valid", 32'(running_mean_valid), 32'd0);
        chk("arst ready", 32'(sample_ready),       32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        acc("d1", 32'd1, 32'd0, 1'b0);
        acc("d2", 32'd2, 32'd0, 1'b0);
        acc("d3", 32'd3, 32'd1, 1'b0);
        acc("d4", 32'd4, 32'd2, 1'b1);
        step("end", 1'b0, 1'b0, 32'd0, 1'b0, 32'd2, 1'b1);

        repeat (3) @(posedge clock);
        #2;
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
